// File: rtl/uart_axis_tx.sv
// AXI-Stream to UART serializer: one character per handshake, framed as
// start / data LSB-first / optional parity / stop bits, paced by an external baud strobe.
module uart_axis_tx #(
    parameter int PARITY_ENA  = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int DATA_BITS   = 8
) (
    input  logic       aclk,
    input  logic       arst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       uart_ena,
    output logic       txd
);
    localparam int N  = 1 + DATA_BITS + PARITY_ENA + STOP_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           txd_q, txd_d;
    logic           tready_q, tready_d;

    logic [7:0]     data_m;
    logic           par;
    logic [N-1:0]   frame;

    assign data_m = s_axis_tdata & DMASK;

    always_comb begin
        par = 1'b0;
        if (PARITY_TYPE == 0)      par = ^data_m;
        else if (PARITY_TYPE == 1) par = ~(^data_m);
        else if (PARITY_TYPE == 2) par = 1'b1;
        else                       par = 1'b0;
    end

    // Frame bit 0 goes out first; unused upper positions default to stop (1).
    always_comb begin
        frame    = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            frame[1 + i] = data_m[i];
        end
        if (PARITY_ENA != 0) begin
            frame[1 + DATA_BITS] = par;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            txd_q    <= 1'b1;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
            tready_q <= tready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        txd_d    = txd_q;
        tready_d = tready_q;
        unique case (state_q)
            ST_IDLE: begin
                txd_d    = 1'b1;
                tready_d = 1'b1;
                // tready_q gates the handshake so the cycle right after reset accepts nothing.
                if (s_axis_tvalid && tready_q) begin
                    shift_d  = frame;
                    cnt_d    = CW'(N);
                    state_d  = ST_SEND;
                    tready_d = 1'b0;
                end
            end
            ST_SEND: begin
                tready_d = 1'b0;
                if (uart_ena) begin
                    if (cnt_q != '0) begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b1, shift_q[N-1:1]};
                        cnt_d   = cnt_q - CW'(1);
                    end else begin
                        // Last stop bit just finished its full baud period.
                        txd_d    = 1'b1;
                        state_d  = ST_IDLE;
                        tready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign txd           = txd_q;
    assign s_axis_tready = tready_q;
endmodule

// File: tb/tb_uart_axis_tx.sv
// Bench for uart_axis_tx: two parameterisations share clock, reset and baud strobe;
// frames are checked mid-bit against a frame model built from the framing rules.
module tb_uart_axis_tx;
    logic       aclk;
    logic       arst;
    logic       uart_ena;
    logic [7:0] tdata1, tdata2;
    logic       tvalid1, tvalid2;
    logic       tready1, tready2;
    logic       txd1, txd2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hs1   = 0;

    uart_axis_tx #(.PARITY_ENA(1), .PARITY_TYPE(1), .STOP_BITS(1), .DATA_BITS(8)) dut1 (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1),
        .s_axis_tready(tready1), .uart_ena(uart_ena), .txd(txd1)
    );

    uart_axis_tx #(.PARITY_ENA(0), .PARITY_TYPE(0), .STOP_BITS(2), .DATA_BITS(7)) dut2 (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata2), .s_axis_tvalid(tvalid2),
        .s_axis_tready(tready2), .uart_ena(uart_ena), .txd(txd2)
    );

    initial begin
        aclk = 1'b0;
        forever #50 aclk = ~aclk;
    end

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (tvalid1 && tready1) hs1 <= hs1 + 1;
    end

    // Baud strobe: one cycle high every 100 clocks, changed on the falling edge.
    initial begin
        int bcnt;
        bcnt = 0;
        uart_ena = 1'b0;
        forever begin
            @(negedge aclk);
            uart_ena = (bcnt == 99);
            bcnt = (bcnt == 99) ? 0 : bcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txsel(input bit sel);
        return sel ? txd2 : txd1;
    endfunction

    function automatic logic rdysel(input bit sel);
        return sel ? tready2 : tready1;
    endfunction

    // Expected frame in transmit order, from the configuration of the selected instance.
    function automatic void model(input logic [7:0] b, input bit sel,
                                  output logic [11:0] bits, output int n);
        int db, pe, pt, sb, ones;
        if (sel) begin db = 7; pe = 0; pt = 0; sb = 2; end
        else     begin db = 8; pe = 1; pt = 1; sb = 1; end
        bits    = '1;
        bits[0] = 1'b0;
        ones    = 0;
        for (int i = 0; i < db; i++) begin
            bits[1 + i] = b[i];
            ones += int'(b[i]);
        end
        n = 1 + db;
        if (pe != 0) begin
            case (pt)
                0:       bits[n] = ((ones % 2) == 1);
                1:       bits[n] = ((ones % 2) == 0);
                2:       bits[n] = 1'b1;
                default: bits[n] = 1'b0;
            endcase
            n = n + 1;
        end
        n = n + sb;
    endfunction

    task automatic send(input bit sel, input logic [7:0] b, input bit hold);
        int k;
        @(negedge aclk);
        if (sel) begin tdata2 = b; tvalid2 = 1'b1; end
        else     begin tdata1 = b; tvalid1 = 1'b1; end
        k = 0;
        while (rdysel(sel) !== 1'b1 && k < 2000) begin
            @(negedge aclk);
            k++;
        end
        chk("send_ready_timeout", 32'(k < 2000), 32'(1));
        @(negedge aclk);
        if (!hold) begin
            if (sel) tvalid2 = 1'b0;
            else     tvalid1 = 1'b0;
        end
    endtask

    task automatic wait_fall(input bit sel, output int t);
        int k;
        k = 0;
        while (txsel(sel) !== 1'b0 && k < 400) begin
            @(negedge aclk);
            k++;
        end
        chk("start_bit_timeout", 32'(k < 400), 32'(1));
        t = cyc;
    endtask

    task automatic check_frame(input bit sel, input logic [7:0] b, input bit scramble,
                               output int t0);
        logic [11:0] bits;
        int n, k;
        model(b, sel, bits, n);
        wait_fall(sel, t0);
        repeat (50) @(negedge aclk);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("frame%0d_%02h_bit%0d", sel, b, i), 32'(txsel(sel)), 32'(bits[i]));
            chk($sformatf("frame%0d_%02h_busy%0d", sel, b, i), 32'(rdysel(sel)), 32'(0));
            if (scramble) begin
                tdata1 = 8'($urandom);
                tdata2 = 8'($urandom);
            end
            if (i < n - 1) repeat (100) @(negedge aclk);
        end
        k = 0;
        while (rdysel(sel) !== 1'b1 && k < 200) begin
            @(negedge aclk);
            k++;
        end
        chk($sformatf("frame%0d_%02h_length", sel, b), 32'(cyc - t0), 32'(100 * n));
        chk($sformatf("frame%0d_%02h_idle_txd", sel, b), 32'(txsel(sel)), 32'(1));
    endtask

    initial begin
        int ta, tb2, h0;
        logic [7:0] rb;
        arst = 1'b1;
        tdata1 = 8'h00; tdata2 = 8'h00;
        tvalid1 = 1'b0; tvalid2 = 1'b0;

        // Reset held for 1 us.
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("reset_txd", 32'(txd1), 32'(1));
            chk("reset_tready", 32'(tready1), 32'(0));
            chk("reset_tready2", 32'(tready2), 32'(0));
        end
        arst = 1'b0;
        @(negedge aclk);
        chk("ready_after_reset", 32'(tready1), 32'(1));
        chk("ready2_after_reset", 32'(tready2), 32'(1));

        // No valid: line stays idle across several baud strobes.
        repeat (300) @(negedge aclk);
        chk("idle_txd", 32'(txd1), 32'(1));
        chk("idle_ready", 32'(tready1), 32'(1));

        send(0, 8'h55, 0);
        check_frame(0, 8'h55, 0, ta);

        // Back-to-back with tvalid held high.
        h0 = hs1;
        send(0, 8'h00, 1);
        tdata1 = 8'hFF;
        check_frame(0, 8'h00, 0, ta);
        @(negedge aclk);
        tvalid1 = 1'b0;
        check_frame(0, 8'hFF, 0, tb2);
        chk("b2b_gap", 32'(tb2 - ta >= 100 * 12), 32'(1));
        repeat (300) @(negedge aclk);
        chk("b2b_handshakes", 32'(hs1 - h0), 32'(2));

        // Data changes while busy must not disturb the frame.
        send(0, 8'hC3, 0);
        check_frame(0, 8'hC3, 1, ta);

        // Reset in the middle of a data bit.
        send(0, 8'h3C, 0);
        wait_fall(0, ta);
        repeat (250) @(negedge aclk);
        arst = 1'b1;
        #1;
        chk("midframe_reset_txd", 32'(txd1), 32'(1));
        chk("midframe_reset_ready", 32'(tready1), 32'(0));
        repeat (10) @(negedge aclk);
        chk("midframe_reset_hold_txd", 32'(txd1), 32'(1));
        arst = 1'b0;
        @(negedge aclk);
        chk("midframe_release_ready", 32'(tready1), 32'(1));
        send(0, 8'hA5, 0);
        check_frame(0, 8'hA5, 0, ta);

        // Second configuration: no parity, 2 stop bits, 7 data bits.
        send(1, 8'h41, 0);
        check_frame(1, 8'h41, 1, ta);
        chk("other_inst_idle", 32'(txd1), 32'(1));

        for (int r = 0; r < 4; r++) begin
            rb = 8'($urandom);
            send(0, rb, 0);
            check_frame(0, rb, 1, ta);
        end
        for (int r = 0; r < 3; r++) begin
            rb = 8'($urandom);
            send(1, rb, 0);
            check_frame(1, rb, 1, ta);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_axis_tx.md
# uart_axis_tx

AXI-Stream to UART serializer. It accepts one character per AXIS handshake and shifts it out on `txd` as a single asynchronous serial frame: start bit, data LSB first, optional parity, stop bits. Bit timing comes from an external one-cycle baud enable strobe (`uart_ena`) generated elsewhere in the design. The block sits between a byte-stream producer and the UART pin.

## Interface
Parameters:
- `PARITY_ENA`, default 0: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_TYPE`, default 0: parity sense when enabled.
  - 0: even.
  - 1: odd.
  - 2: mark (always 1).
  - 3: space (always 0).
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `DATA_BITS`, default 8: data bits per frame, 5..8. Bits taken from `s_axis_tdata[DATA_BITS-1:0]`.

Ports (one clock; reset is asynchronous and active-high):
- `aclk` in 1: the single clock for the AXIS side and the serializer.
- `arst` in 1: asynchronous, active-high reset.
- `s_axis_tdata` in 8: character to send.
- `s_axis_tvalid` in 1: producer has data.
- `s_axis_tready` out 1: block is idle and can accept a character.
- `uart_ena` in 1: baud strobe, high for one `aclk` cycle per bit period.
- `txd` out 1: serial output, idle high.

## Operation
Frame length is N = 1 + DATA_BITS + PARITY_ENA + STOP_BITS bits. The frame, in transmit order, is:
- start bit (0);
- d[0] .. d[DATA_BITS-1];
- parity bit, if enabled;
- STOP_BITS ones.

Parity is computed over d[DATA_BITS-1:0] only:
- even: XOR of the data bits;
- odd: inverted XOR of the data bits;
- mark: 1;
- space: 0.

State machine:
- IDLE
  - `s_axis_tready`=1, `txd`=1.
  - On `s_axis_tvalid`&&`s_axis_tready`, load the frame shift register and set the bit counter to N, then go to SEND.
  - `uart_ena` is ignored in IDLE.
- SEND
  - `s_axis_tready`=0.
  - On each `uart_ena` with counter>0: drive `txd` with the next frame bit, shift, and decrement the counter.
  - On `uart_ena` with counter==0: the last stop bit has completed its full period. Keep `txd`=1 and go to IDLE.
  - Cycles without `uart_ena` hold `txd`.

Rules:
- Characters are never dropped or duplicated. Exactly one frame is sent per accepted handshake.
- `s_axis_tdata` is sampled only on the handshake cycle. Later changes to it do not affect the frame in flight.
- `s_axis_tvalid` low in IDLE: no activity; `txd` stays 1 indefinitely.

## Timing
- Reset values:
  - `txd`=1.
  - `s_axis_tready`=0 while `arst` is high.
  - Shift register and counter cleared.
- `s_axis_tready` goes to 1 on the first `aclk` edge after `arst` deasserts.
- Reset mid-frame aborts the frame immediately (asynchronously): `txd`=1, and the block returns to IDLE after release.
- Handshake to start bit: the handshake takes effect at edge k. `txd` falls at the edge of the first `uart_ena` cycle after k.
  - If `uart_ena` coincides with the handshake cycle, that pulse is not used for the start bit.
- Each bit lasts exactly one baud period, from one `uart_ena` pulse to the next.
- `s_axis_tready` reasserts on the edge following the `uart_ena` that ends the last stop bit.
- Back-to-back: a handshake in that cycle starts the next frame at the following `uart_ena`.
  - The stop/idle time between frames is therefore STOP_BITS plus at least one extra baud period of high `txd`.
- Unregistered paths: none. `txd` and `s_axis_tready` are flop outputs.

## Test plan
Common setup: 100 ns clock, `uart_ena` every 100 clocks, PARITY_ENA=1, PARITY_TYPE=1 (odd), STOP_BITS=1, DATA_BITS=8. This gives N=11.

1. Reset: hold `arst` 1 µs.
   - Required: `txd`=1 and `s_axis_tready`=0 throughout.
   - Required: `s_axis_tready`=1 one clock after release.
2. Send 0x55.
   - Required `txd` sequence, sampled mid-bit: 0,1,0,1,0,1,0,1,0,1,1 (odd parity=1).
   - Required: each bit lasts 100 clocks; `s_axis_tready` low for the whole frame.
3. Send 0x00 then 0xFF back-to-back with `s_axis_tvalid` held.
   - Required frames: 0,0×8,1,1 and 0,1×8,0,1.
   - Required: ≥1 extra high baud period between the frames; exactly two handshakes.
4. Toggle `s_axis_tdata` while `s_axis_tready`=0 during a frame.
   - Required: the frame in flight is unchanged.
5. Assert `arst` mid-data-bit.
   - Required: `txd`=1 immediately.
   - Required: after release, a new 0xA5 frame is sent cleanly: 0,1,0,1,0,0,1,0,1,1,1.
6. Reconfigure PARITY_ENA=0, STOP_BITS=2, DATA_BITS=7 and send 0x41.
   - Required frame: 0,1,0,0,0,0,0,1,1,1 (N=10).
